// File: rtl/led_pwm_pkg.sv
// -----------------------------------------------------------------------------
// led_pwm_pkg
//   Shared definitions for the time-multiplexed RGB LED PWM driver.
//   - Logical colour indices used by the pattern engines.
//   - Default badge colour map: 11 LEDs with mixed RGB/BGR/GRB sink wiring.
//     Each LED takes 2*NUM_COLORS bits. Field c (bits [2c+1:2c]) holds the
//     physical sink number for logical colour c.
//   - Scan FSM state type and a frame length helper.
// -----------------------------------------------------------------------------
package led_pwm_pkg;

    localparam int COLOR_RED   = 0;
    localparam int COLOR_GREEN = 1;
    localparam int COLOR_BLUE  = 2;

    localparam int DFLT_NUM_LEDS   = 11;
    localparam int DFLT_NUM_COLORS = 3;

    // Per-LED 6-bit map entries written as {blue, green, red} sink numbers.
    localparam logic [5:0] MAP_RGB = {2'd2, 2'd1, 2'd0};
    localparam logic [5:0] MAP_BGR = {2'd0, 2'd1, 2'd2};
    localparam logic [5:0] MAP_GRB = {2'd2, 2'd0, 2'd1};

    // LED 0 sits in the least significant slice.
    localparam logic [DFLT_NUM_LEDS*2*DFLT_NUM_COLORS-1:0] DFLT_COLOR_MAP = {
        MAP_GRB,  // LED 10
        MAP_BGR,  // LED 9
        MAP_RGB,  // LED 8
        MAP_RGB,  // LED 7
        MAP_GRB,  // LED 6
        MAP_BGR,  // LED 5
        MAP_BGR,  // LED 4
        MAP_RGB,  // LED 3
        MAP_GRB,  // LED 2
        MAP_BGR,  // LED 1
        MAP_RGB   // LED 0
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // Cycles in one full frame: every phase is a blanking gap plus a PWM period.
    function automatic int frame_len(input int num_colors, input int blank_cycles,
                                     input int pwm_bits);
        return num_colors * (blank_cycles + (1 << pwm_bits));
    endfunction

endpackage

// File: rtl/led_pwm_phase_timer.sv
// -----------------------------------------------------------------------------
// led_pwm_phase_timer
//   Scan sequencer: for each colour phase runs BLANK for BLANK_CYCLES cycles,
//   then DRIVE for one PWM period (2**PWM_BITS cycles), then moves on to the
//   next phase, wrapping to phase 0 after the last colour.
//   The state held here names the slot the output stage will present after
//   the next clock edge.
// Ports
//   clk, rst_    clock, asynchronous active-low reset
//   en           scan enable; low parks the sequencer at phase 0 BLANK, count 0
//   phase        current colour phase
//   k            PWM counter within DRIVE
//   drive        slot is a DRIVE slot
//   swap         slot is the last DRIVE cycle of the last phase
//   frame_start  slot is the first BLANK cycle of phase 0
// -----------------------------------------------------------------------------
module led_pwm_phase_timer
    import led_pwm_pkg::*;
#(
    parameter int NUM_COLORS   = 3,
    parameter int PWM_BITS     = 8,
    parameter int BLANK_CYCLES = 4,
    parameter int PH_W         = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                en,
    output logic [PH_W-1:0]     phase,
    output logic [PWM_BITS-1:0] k,
    output logic                drive,
    output logic                swap,
    output logic                frame_start
);

    // One counter serves both the blanking gap and the PWM period.
    localparam int CNT_W = (PWM_BITS >= $clog2(BLANK_CYCLES)) ? PWM_BITS : $clog2(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'((1 << PWM_BITS) - 1);
    localparam logic [PH_W-1:0]  PHASE_LAST = PH_W'(NUM_COLORS - 1);

    scan_state_e      state;
    logic [PH_W-1:0]  phase_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= ST_BLANK;
            phase_q <= '0;
            cnt     <= '0;
        end else if (!en) begin
            state   <= ST_BLANK;
            phase_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= ST_DRIVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        state   <= ST_BLANK;
                        cnt     <= '0;
                        phase_q <= (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign phase       = phase_q;
    assign k           = cnt[PWM_BITS-1:0];
    assign drive       = (state == ST_DRIVE);
    assign swap        = (state == ST_DRIVE) && (phase_q == PHASE_LAST) && (cnt == DRIVE_LAST);
    assign frame_start = (state == ST_BLANK) && (phase_q == '0) && (cnt == '0);

endmodule

// File: rtl/led_rgb_pwm_mux.sv
// -----------------------------------------------------------------------------
// led_rgb_pwm_mux
//   Time-multiplexed PWM driver for NUM_LEDS common-sink RGB LEDs.
//   Pattern engines write duty values into a staging array; a commit request
//   copies staging into the active array on the last DRIVE cycle of the frame,
//   so a frame never shows a half-updated picture. Logical colours are remapped
//   to physical sinks at write time through COLOR_MAP.
// Ports
//   clk, rst_        clock, asynchronous active-low reset
//   en               scan enable
//   wr_en            staging write strobe
//   wr_led           LED index (writes to LEDs >= NUM_LEDS are dropped)
//   wr_color         logical colour (colours >= NUM_COLORS are dropped)
//   wr_data          duty value
//   commit           request staging->active copy at the next frame boundary
//   commit_pending   commit accepted, copy not yet done
//   frame_start      one-cycle pulse on the first cycle of each frame
//   ledc             anode drives, registered
//   ledrgb           sink drives, one-hot or zero, registered
// -----------------------------------------------------------------------------
module led_rgb_pwm_mux
    import led_pwm_pkg::*;
#(
    parameter int NUM_LEDS     = DFLT_NUM_LEDS,
    parameter int NUM_COLORS   = DFLT_NUM_COLORS,
    parameter int PWM_BITS     = 8,
    parameter int BLANK_CYCLES = 4,
    parameter logic [NUM_LEDS*2*NUM_COLORS-1:0] COLOR_MAP =
        DFLT_COLOR_MAP[NUM_LEDS*2*NUM_COLORS-1:0],
    parameter int LED_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [LED_W-1:0]      wr_led,
    input  logic [1:0]            wr_color,
    input  logic [PWM_BITS-1:0]   wr_data,
    input  logic                  commit,
    output logic                  commit_pending,
    output logic                  frame_start,
    output logic [NUM_LEDS-1:0]   ledc,
    output logic [NUM_COLORS-1:0] ledrgb
);

    localparam int PH_W  = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;
    localparam int MAP_W = 2 * NUM_COLORS;

    localparam logic [LED_W:0]        LED_LIMIT   = (LED_W + 1)'(NUM_LEDS);
    localparam logic [2:0]            COLOR_LIMIT = 3'(NUM_COLORS);
    localparam logic [NUM_COLORS-1:0] RGB_ONE     = NUM_COLORS'(1);

    // Physical sink for a logical colour on a given LED.
    function automatic logic [1:0] map_field(input logic [LED_W-1:0] led,
                                             input logic [1:0] color);
        return COLOR_MAP[int'(led) * MAP_W + 2 * int'(color) +: 2];
    endfunction

    logic [PWM_BITS-1:0] staging [NUM_LEDS][NUM_COLORS];
    logic [PWM_BITS-1:0] active  [NUM_LEDS][NUM_COLORS];

    logic [PH_W-1:0]     t_phase;
    logic [PWM_BITS-1:0] t_k;
    logic                t_drive;
    logic                t_swap;
    logic                t_frame_start;

    logic [1:0]          wr_phys;
    logic                wr_ok;
    logic                swap_now;
    logic [NUM_LEDS-1:0] ledc_nxt;

    led_pwm_phase_timer #(
        .NUM_COLORS   (NUM_COLORS),
        .PWM_BITS     (PWM_BITS),
        .BLANK_CYCLES (BLANK_CYCLES),
        .PH_W         (PH_W)
    ) u_timer (
        .clk         (clk),
        .rst_        (rst_),
        .en          (en),
        .phase       (t_phase),
        .k           (t_k),
        .drive       (t_drive),
        .swap        (t_swap),
        .frame_start (t_frame_start)
    );

    // A bad map entry (sink >= NUM_COLORS) also drops the write rather than
    // scribbling outside the colour range.
    assign wr_phys  = map_field(wr_led, wr_color);
    assign wr_ok    = wr_en
                   && ({1'b0, wr_led}   < LED_LIMIT)
                   && ({1'b0, wr_color} < COLOR_LIMIT)
                   && ({1'b0, wr_phys}  < COLOR_LIMIT);
    assign swap_now = en && t_swap;

    always_comb begin
        ledc_nxt = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            ledc_nxt[i] = t_drive && (t_k < active[i][t_phase]);
        end
    end

    // Output stage: ledc and ledrgb load together from the same timer slot, so
    // a phase change never overlaps old anodes with a new sink.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ledc           <= '0;
            ledrgb         <= '0;
            frame_start    <= 1'b0;
            commit_pending <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                for (int c = 0; c < NUM_COLORS; c++) begin
                    staging[i][c] <= '0;
                    active[i][c]  <= '0;
                end
            end
        end else begin
            if (en) begin
                ledc        <= ledc_nxt;
                ledrgb      <= t_drive ? (RGB_ONE << t_phase) : '0;
                frame_start <= t_frame_start;
            end else begin
                ledc        <= '0;
                ledrgb      <= '0;
                frame_start <= 1'b0;
            end

            if (wr_ok) begin
                staging[wr_led][wr_phys[PH_W-1:0]] <= wr_data;
            end

            // The copy reads staging before this edge, so a write landing on
            // the swap edge waits for the following commit.
            if (swap_now) begin
                if (commit_pending || commit) begin
                    for (int i = 0; i < NUM_LEDS; i++) begin
                        for (int c = 0; c < NUM_COLORS; c++) begin
                            active[i][c] <= staging[i][c];
                        end
                    end
                end
                commit_pending <= 1'b0;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_rgb_pwm_mux.sv
// -----------------------------------------------------------------------------
// tb_led_rgb_pwm_mux
//   Directed bench: 3 LEDs, 3 colours, 4-bit PWM, 2 blanking cycles.
//   LED0 is wired with a reversed sink order (R->2, G->1, B->0); LEDs 1 and 2
//   use the identity map. exp_active holds the hand-set duty picture that
//   should be on the LEDs, already indexed by physical sink.
// -----------------------------------------------------------------------------
module tb_led_rgb_pwm_mux;
    import led_pwm_pkg::*;

    localparam int NL     = 3;
    localparam int NC     = 3;
    localparam int PB     = 4;
    localparam int BC     = 2;
    localparam int PH_LEN = BC + (1 << PB);
    localparam int FRAME  = frame_len(NC, BC, PB);
    localparam logic [NL*2*NC-1:0] MAP = {6'b10_01_00, 6'b10_01_00, 6'b00_01_10};

    logic          clk = 1'b0;
    logic          rst_;
    logic          en;
    logic          wr_en;
    logic [1:0]    wr_led;
    logic [1:0]    wr_color;
    logic [PB-1:0] wr_data;
    logic          commit;
    logic          commit_pending;
    logic          frame_start;
    logic [NL-1:0] ledc;
    logic [NC-1:0] ledrgb;

    int vectors    = 0;
    int miscompares = 0;
    int exp_active [NL][NC];

    led_rgb_pwm_mux #(
        .NUM_LEDS     (NL),
        .NUM_COLORS   (NC),
        .PWM_BITS     (PB),
        .BLANK_CYCLES (BC),
        .COLOR_MAP    (MAP)
    ) dut (
        .clk            (clk),
        .rst_           (rst_),
        .en             (en),
        .wr_en          (wr_en),
        .wr_led         (wr_led),
        .wr_color       (wr_color),
        .wr_data        (wr_data),
        .commit         (commit),
        .commit_pending (commit_pending),
        .frame_start    (frame_start),
        .ledc           (ledc),
        .ledrgb         (ledrgb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one full frame starting from the edge that shows slot 0, checking
    // every slot. One optional write/commit is presented on the edge that
    // shows slot act_at.
    task automatic check_frame(input int act_at, input logic do_wr, input logic [1:0] led,
                               input logic [1:0] col, input logic [PB-1:0] data,
                               input logic do_commit);
        int            ph;
        int            r;
        logic [NL-1:0] e_c;
        logic [NC-1:0] e_rgb;
        for (int s = 0; s < FRAME; s++) begin
            if (s == act_at) begin
                wr_en    = do_wr;
                wr_led   = led;
                wr_color = col;
                wr_data  = data;
                commit   = do_commit;
            end
            step();
            wr_en  = 1'b0;
            commit = 1'b0;
            if (s == act_at && do_commit)
                chk($sformatf("pending_s%0d", s), 32'(commit_pending), 32'(s != FRAME - 1));
            ph    = s / PH_LEN;
            r     = s % PH_LEN;
            e_rgb = '0;
            e_c   = '0;
            if (r >= BC) begin
                e_rgb = NC'(1) << ph;
                for (int i = 0; i < NL; i++)
                    e_c[i] = ((r - BC) < exp_active[i][ph]);
            end
            chk($sformatf("ledrgb_s%0d", s), 32'(ledrgb), 32'(e_rgb));
            chk($sformatf("ledc_s%0d", s), 32'(ledc), 32'(e_c));
            chk($sformatf("frame_start_s%0d", s), 32'(frame_start), 32'(s == 0));
        end
    endtask

    initial begin
        rst_     = 1'b0;
        en       = 1'b0;
        wr_en    = 1'b0;
        wr_led   = '0;
        wr_color = '0;
        wr_data  = '0;
        commit   = 1'b0;
        for (int i = 0; i < NL; i++)
            for (int c = 0; c < NC; c++)
                exp_active[i][c] = 0;

        // Reset state
        repeat (3) step();
        chk("rst_ledc", 32'(ledc), 32'h0);
        chk("rst_ledrgb", 32'(ledrgb), 32'h0);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        chk("rst_pending", 32'(commit_pending), 32'h0);

        rst_ = 1'b1;
        step();
        chk("idle_ledrgb", 32'(ledrgb), 32'h0);
        chk("idle_frame_start", 32'(frame_start), 32'h0);

        // First frame after enable: dark, blank/drive sink pattern
        en = 1'b1;
        check_frame(-1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);

        // LED1 green = 5, committed at start of frame; visible the frame after
        check_frame(0, 1'b1, 2'd1, 2'd1, 4'd5, 1'b1);
        chk("f2_pending_clr", 32'(commit_pending), 32'h0);
        exp_active[1][1] = 5;
        check_frame(-1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);

        // Write + commit on the swap edge: old staging goes live, new value waits
        check_frame(FRAME - 1, 1'b1, 2'd2, 2'd2, 4'd9, 1'b1);
        chk("f4_pending_clr", 32'(commit_pending), 32'h0);
        check_frame(20, 1'b0, 2'd0, 2'd0, 4'd0, 1'b1);
        exp_active[2][2] = 9;
        check_frame(-1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);

        // LED0 logical red lands on physical sink 2
        check_frame(0, 1'b1, 2'd0, 2'd0, 4'd15, 1'b1);
        exp_active[0][2] = 15;

        // Out-of-range LED and colour writes must not disturb staging
        check_frame(5, 1'b1, 2'd3, 2'd0, 4'd7, 1'b1);
        check_frame(5, 1'b1, 2'd1, 2'd3, 4'd7, 1'b1);
        check_frame(-1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);

        // en drop mid-DRIVE with a commit pending
        wr_en    = 1'b1;
        wr_led   = 2'd2;
        wr_color = 2'd1;
        wr_data  = 4'd3;
        commit   = 1'b1;
        step();
        wr_en  = 1'b0;
        commit = 1'b0;
        chk("en_pending_set", 32'(commit_pending), 32'h1);
        repeat (24) step();
        chk("en_pre_ledrgb", 32'(ledrgb), 32'h2);
        chk("en_pre_ledc", 32'(ledc), 32'h2);
        en = 1'b0;
        step();
        chk("en_off_ledc", 32'(ledc), 32'h0);
        chk("en_off_ledrgb", 32'(ledrgb), 32'h0);
        chk("en_off_frame_start", 32'(frame_start), 32'h0);
        chk("en_off_pending", 32'(commit_pending), 32'h1);
        repeat (3) step();
        chk("en_idle_ledrgb", 32'(ledrgb), 32'h0);
        en = 1'b1;
        check_frame(-1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
        chk("en_pending_clr", 32'(commit_pending), 32'h0);
        exp_active[2][1] = 3;
        check_frame(-1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);

        // Asynchronous reset mid-DRIVE with a commit pending
        commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (20) step();
        chk("rst_pre_ledrgb", 32'(ledrgb), 32'h2);
        chk("rst_pre_ledc", 32'(ledc), 32'h6);
        chk("rst_pre_pending", 32'(commit_pending), 32'h1);
        #2;
        rst_ = 1'b0;
        #1;
        chk("rst_async_ledc", 32'(ledc), 32'h0);
        chk("rst_async_ledrgb", 32'(ledrgb), 32'h0);
        chk("rst_async_pending", 32'(commit_pending), 32'h0);
        chk("rst_async_frame_start", 32'(frame_start), 32'h0);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        for (int i = 0; i < NL; i++)
            for (int c = 0; c < NC; c++)
                exp_active[i][c] = 0;

        // Duty data was lost: committing cleared staging keeps everything dark
        check_frame(0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b1);
        check_frame(-1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
